// File: rtl/icache_pkg.sv
// Shared types and helpers for the N-way instruction cache and its byte-serial
// memory sequencer.
package icache_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STORE  = 2'd2,
        ST_REFILL = 2'd3
    } state_t;

    localparam logic [2:0] SZ_BYTE = 3'd1;
    localparam logic [2:0] SZ_HALF = 3'd2;
    localparam logic [2:0] SZ_WORD = 3'd4;

    function automatic logic [BYTE_W-1:0] byte_sel(input logic [WORD_W-1:0] word,
                                                   input logic [1:0]        idx);
        byte_sel = word[idx*BYTE_W +: BYTE_W];
    endfunction

    function automatic logic [WORD_W-1:0] size_mask(input logic [2:0] size);
        case (size)
            SZ_BYTE: size_mask = 32'h0000_00ff;
            SZ_HALF: size_mask = 32'h0000_ffff;
            default: size_mask = 32'hffff_ffff;
        endcase
    endfunction

endpackage

// File: rtl/icache_way.sv
// One way of the instruction cache: valid bits (async clear), tag and data
// arrays, a lookup read port, a refill write port and a snoop invalidate port.
module icache_way
    import icache_pkg::*;
#(
    parameter int SET_WIDTH = 9,
    parameter int TAG_W     = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SET_WIDTH-1:0] rd_set,
    input  logic [TAG_W-1:0]     rd_tag,
    output logic                 match,
    output logic [WORD_W-1:0]    rd_data,
    input  logic                 wr_en,
    input  logic [SET_WIDTH-1:0] wr_set,
    input  logic [TAG_W-1:0]     wr_tag,
    input  logic [WORD_W-1:0]    wr_data,
    output logic                 wr_valid,
    input  logic                 inv_en,
    input  logic [SET_WIDTH-1:0] inv_set,
    input  logic [TAG_W-1:0]     inv_tag
);

    localparam int SETS = 1 << SET_WIDTH;

    logic [SETS-1:0]   valid;
    logic [TAG_W-1:0]  tag_mem  [SETS];
    logic [WORD_W-1:0] data_mem [SETS];
    logic              inv_hit;

    assign inv_hit = inv_en && valid[inv_set] && (tag_mem[inv_set] == inv_tag);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_set] <= 1'b1;
        end else if (inv_hit) begin
            valid[inv_set] <= 1'b0;
        end
    end

    // Arrays are left unreset; the valid bits alone qualify their contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_set]  <= wr_tag;
            data_mem[wr_set] <= wr_data;
        end
    end

    assign match    = valid[rd_set] && (tag_mem[rd_set] == rd_tag);
    assign rd_data  = data_mem[rd_set];
    assign wr_valid = valid[wr_set];

endmodule

// File: rtl/icache_nway.sv
// N-way set-associative instruction cache with round-robin replacement and a
// byte-serial RAM sequencer shared between line refills and the load/store unit.
module icache_nway
    import icache_pkg::*;
#(
    parameter int WAYS       = 2,
    parameter int SET_WIDTH  = 9,
    parameter int ADDR_WIDTH = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_hit,
    output logic [31:0] if_inst,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [2:0]  ls_size,
    input  logic [31:0] ls_wdata,
    output logic        ls_busy,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
);

    localparam int TAG_W = ADDR_WIDTH - SET_WIDTH - 2;
    localparam int SETS  = 1 << SET_WIDTH;
    localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int WA_W  = ADDR_WIDTH - 2;

    // LSU handshake: a request is taken in a cycle where ls_req is high, the
    // sequencer is idle and rdy is high; ls_busy then stays high until the
    // cycle ls_done pulses, and ls_req is ignored meanwhile.
    state_t state, state_next;

    logic [2:0]        cnt;
    logic [31:0]       op_addr;
    logic [31:0]       op_wdata;
    logic [2:0]        op_size;
    logic [31:0]       rbuf;
    logic              pend_valid;
    logic [WA_W-1:0]   pend_addr;
    logic [PTR_W-1:0]  vptr [SETS];

    logic [WAYS-1:0]   match;
    logic [WAYS-1:0]   wr_valid;
    logic [WAYS-1:0]   wr_en_w;
    logic [WORD_W-1:0] way_data [WAYS];
    logic              hit_any;
    logic [WORD_W-1:0] hit_data;

    logic [SET_WIDTH-1:0] lk_set, fill_set, inv_set;
    logic [TAG_W-1:0]     lk_tag, fill_tag, inv_tag;
    logic [WORD_W-1:0]    fill_line;
    logic [31:0]          refill_base;
    logic [PTR_W-1:0]     fill_way;
    logic                 fill_found;

    logic       accept;
    logic       load_done, store_done, refill_done;
    logic [2:0] rd_last, rd_idx;
    logic [1:0] cap_idx;
    logic       unused_ok;

    assign lk_set      = if_addr[SET_WIDTH+1:2];
    assign lk_tag      = if_addr[ADDR_WIDTH-1:SET_WIDTH+2];
    assign fill_set    = pend_addr[SET_WIDTH-1:0];
    assign fill_tag    = pend_addr[WA_W-1:SET_WIDTH];
    assign inv_set     = op_addr[SET_WIDTH+1:2];
    assign inv_tag     = op_addr[ADDR_WIDTH-1:SET_WIDTH+2];
    assign fill_line   = {mem_din, rbuf[23:0]};
    assign refill_base = 32'({pend_addr, 2'b00});
    assign unused_ok   = ^{if_addr[31:ADDR_WIDTH], if_addr[1:0]};

    assign ls_busy     = (state == ST_LOAD) || (state == ST_STORE);
    assign load_done   = rdy && (state == ST_LOAD)   && (cnt == op_size);
    assign store_done  = rdy && (state == ST_STORE)  && (cnt == op_size - 3'd1);
    assign refill_done = rdy && (state == ST_REFILL) && (cnt == SZ_WORD);

    // The byte returned in this cycle belongs to the address issued at cnt-1.
    // When stalled, or once every address is out, that address is re-issued
    // so the next capture still sees the right byte.
    assign cap_idx = cnt[1:0] - 2'd1;
    assign rd_last = (state == ST_LOAD) ? op_size : SZ_WORD;
    assign rd_idx  = ((!rdy && cnt != 3'd0) || cnt == rd_last) ? cnt - 3'd1 : cnt;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        icache_way #(
            .SET_WIDTH (SET_WIDTH),
            .TAG_W     (TAG_W)
        ) u_way (
            .clk      (clk),
            .rst      (rst),
            .rd_set   (lk_set),
            .rd_tag   (lk_tag),
            .match    (match[w]),
            .rd_data  (way_data[w]),
            .wr_en    (wr_en_w[w]),
            .wr_set   (fill_set),
            .wr_tag   (fill_tag),
            .wr_data  (fill_line),
            .wr_valid (wr_valid[w]),
            .inv_en   (store_done),
            .inv_set  (inv_set),
            .inv_tag  (inv_tag)
        );
    end

    always_comb begin
        hit_any  = |match;
        hit_data = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (match[w]) hit_data = hit_data | way_data[w];
        end
    end

    // First invalid way wins; otherwise the set's round-robin victim.
    always_comb begin
        fill_way   = vptr[fill_set];
        fill_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!fill_found && !wr_valid[w]) begin
                fill_way   = PTR_W'(w);
                fill_found = 1'b1;
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            wr_en_w[w] = refill_done && (fill_way == PTR_W'(w));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else if (rdy) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        mem_a      = '0;
        mem_dout   = '0;
        mem_wr     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rdy && ls_req) begin
                    accept     = 1'b1;
                    state_next = ls_we ? ST_STORE : ST_LOAD;
                end else if (rdy && pend_valid) begin
                    state_next = ST_REFILL;
                end
            end
            ST_LOAD: begin
                mem_a = op_addr + 32'(rd_idx);
                if (load_done) state_next = ST_IDLE;
            end
            ST_STORE: begin
                mem_a    = op_addr + 32'(cnt);
                mem_dout = byte_sel(op_wdata, cnt[1:0]);
                mem_wr   = rdy;
                if (store_done) state_next = ST_IDLE;
            end
            ST_REFILL: begin
                mem_a = refill_base + 32'(rd_idx);
                if (refill_done) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            op_addr    <= '0;
            op_wdata   <= '0;
            op_size    <= '0;
            rbuf       <= '0;
            ls_rdata   <= '0;
            ls_done    <= 1'b0;
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            if_hit     <= 1'b0;
            if_inst    <= '0;
        end else if (rdy) begin
            if_hit  <= if_req && hit_any;
            if_inst <= (if_req && hit_any) ? hit_data : '0;
            ls_done <= load_done || store_done;

            // A miss seen during the refill's final cycle is not latched: the
            // arrays do not show the new line yet and it would be duplicated.
            if (refill_done) begin
                pend_valid <= 1'b0;
            end else if (if_req && !hit_any && !pend_valid) begin
                pend_valid <= 1'b1;
                pend_addr  <= if_addr[ADDR_WIDTH-1:2];
            end

            if (state == ST_IDLE) begin
                cnt  <= '0;
                rbuf <= '0;
            end else begin
                cnt <= cnt + 3'd1;
            end

            if (accept) begin
                op_addr  <= ls_addr;
                op_wdata <= ls_wdata;
                op_size  <= ls_size;
            end

            if ((state == ST_LOAD || state == ST_REFILL) && cnt != 3'd0) begin
                rbuf[cap_idx*BYTE_W +: BYTE_W] <= mem_din;
            end

            if (load_done) begin
                ls_rdata <= (rbuf | (WORD_W'(mem_din) << (BYTE_W*cap_idx)))
                            & size_mask(op_size);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) vptr[s] <= '0;
        end else if (refill_done) begin
            vptr[fill_set] <= (vptr[fill_set] == PTR_W'(WAYS - 1)) ? '0
                              : vptr[fill_set] + 1'b1;
        end
    end

endmodule

// File: tb/tb_icache_nway.sv
// Directed bench for icache_nway: fetch latency, replacement, loads, stores
// with snoop invalidation, rdy stalls and reset mid-transfer.
module tb_icache_nway;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_hit;
    logic [31:0] if_inst;
    logic        ls_req, ls_we;
    logic [31:0] ls_addr;
    logic [2:0]  ls_size;
    logic [31:0] ls_wdata;
    logic        ls_busy, ls_done;
    logic [31:0] ls_rdata;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    icache_nway #(.WAYS(2), .SET_WIDTH(9), .ADDR_WIDTH(17)) dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_hit   (if_hit),
        .if_inst  (if_inst),
        .ls_req   (ls_req),
        .ls_we    (ls_we),
        .ls_addr  (ls_addr),
        .ls_size  (ls_size),
        .ls_wdata (ls_wdata),
        .ls_busy  (ls_busy),
        .ls_done  (ls_done),
        .ls_rdata (ls_rdata),
        .mem_din  (mem_din),
        .mem_dout (mem_dout),
        .mem_a    (mem_a),
        .mem_wr   (mem_wr)
    );

    function automatic logic [7:0] init_byte(input int a);
        case (a)
            'h1000: init_byte = 8'h13;
            'h1001: init_byte = 8'h05;
            'h0000: init_byte = 8'h11;
            'h0001: init_byte = 8'h22;
            'h0002: init_byte = 8'h33;
            'h0003: init_byte = 8'h44;
            'h0800: init_byte = 8'hdd;
            'h0801: init_byte = 8'hcc;
            'h0802: init_byte = 8'hbb;
            'h0803: init_byte = 8'haa;
            'h0104: init_byte = 8'hef;
            'h0105: init_byte = 8'hbe;
            'h0200: init_byte = 8'h67;
            'h0201: init_byte = 8'h80;
            'h0300: init_byte = 8'h93;
            'h0302: init_byte = 8'h10;
            default: init_byte = 8'h00;
        endcase
    endfunction

    // RAM model: one-cycle read latency, write on mem_wr.
    logic [7:0] ram [0:8191];
    logic       ram_ready = 1'b0;
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int a = 0; a < 8192; a++) ram[a] <= init_byte(a);
            ram_ready <= 1'b1;
        end else if (mem_wr) begin
            ram[mem_a[12:0]] <= mem_dout;
        end
        mem_din <= ram[mem_a[12:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    // Holds if_req from the request cycle and counts cycles until if_hit;
    // rdy is dropped for stall_len cycles starting stall_from cycles later.
    task automatic fetch_expect(input string tag, input logic [31:0] addr,
                                input int exp_lat, input logic [31:0] exp_inst,
                                input int stall_from, input int stall_len);
        int lat;
        logic [31:0] inst;
        lat  = 0;
        inst = '0;
        tick();
        if_req  = 1'b1;
        if_addr = addr;
        for (int k = 1; k <= 40; k++) begin
            tick();
            rdy = !(k >= stall_from && k < stall_from + stall_len);
            if (if_hit) begin
                lat  = k;
                inst = if_inst;
                break;
            end
        end
        if_req = 1'b0;
        rdy    = 1'b1;
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " inst"}, inst, exp_inst);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n_done, done_lat, hit_lat;
        logic [31:0] e;

        rst = 1'b0; rdy = 1'b1; if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_size = '0; ls_wdata = '0;
        tick(); tick(); tick();
        check("reset if_hit", if_hit, 0);
        check("reset if_inst", if_inst, 0);
        check("reset ls_busy", ls_busy, 0);
        check("reset ls_done", ls_done, 0);
        check("reset ls_rdata", ls_rdata, 0);
        check("reset mem_a", mem_a, 0);
        check("reset mem_wr", mem_wr, 0);
        check("reset mem_dout", mem_dout, 0);
        rst = 1'b1;
        tick();

        fetch_expect("cold 0x1000", 32'h1000, 8, 32'h0000_0513, 0, 0);
        fetch_expect("repeat 0x1000", 32'h1000, 1, 32'h0000_0513, 0, 0);

        // Store a word over a cached line.
        exp_q.push_back(8'hef); exp_q.push_back(8'hbe);
        exp_q.push_back(8'had); exp_q.push_back(8'hde);
        tick();
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h1000; ls_size = 3'd4;
        ls_wdata = 32'hdead_beef;
        for (int k = 1; k <= 4; k++) begin
            tick();
            ls_req = 1'b0;
            check("store busy", ls_busy, 1);
            check("store mem_wr", mem_wr, 1);
            check("store mem_a", mem_a, 32'h1000 + k - 1);
            e = {24'h0, exp_q.pop_front()};
            check("store byte", {24'h0, mem_dout}, e);
        end
        tick();
        check("store done", ls_done, 1);
        check("store mem_wr after", mem_wr, 0);
        fetch_expect("refetch after store", 32'h1000, 8, 32'hdead_beef, 0, 0);

        // Halfword load with a concurrent fetch miss left pending.
        tick();
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0104; ls_size = 3'd2;
        if_req = 1'b1; if_addr = 32'h0200;
        n_done = 0; done_lat = 0; hit_lat = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            ls_req = 1'b0;
            if (k == 1) begin
                check("load busy", ls_busy, 1);
                check("load mem_a0", mem_a, 32'h0104);
            end
            if (k == 2) check("load mem_a1", mem_a, 32'h0105);
            if (ls_done) begin
                n_done++;
                if (done_lat == 0) begin
                    done_lat = k;
                    check("load rdata", ls_rdata, 32'h0000_beef);
                end
            end
            if (if_hit) begin
                hit_lat = k;
                check("pending refill inst", if_inst, 32'h0000_8067);
                break;
            end
        end
        if_req = 1'b0;
        check("load done latency", done_lat, 4);
        check("load done pulses", n_done, 1);
        check("pending refill latency", hit_lat, 11);

        // Three lines into set 0 of a two-way cache.
        do_reset();
        fetch_expect("set0 0x0000", 32'h0000, 8, 32'h4433_2211, 0, 0);
        fetch_expect("set0 0x0800", 32'h0800, 8, 32'haabb_ccdd, 0, 0);
        fetch_expect("set0 0x1000", 32'h1000, 8, 32'hdead_beef, 0, 0);
        fetch_expect("kept 0x0800", 32'h0800, 1, 32'haabb_ccdd, 0, 0);
        fetch_expect("evicted 0x0000", 32'h0000, 8, 32'h4433_2211, 0, 0);

        fetch_expect("stalled refill", 32'h0300, 11, 32'h0010_0093, 3, 3);

        // Reset in the middle of a store.
        tick();
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h0400; ls_size = 3'd4;
        ls_wdata = 32'h1234_5678;
        tick();
        ls_req = 1'b0;
        check("abort store mem_wr before", mem_wr, 1);
        tick();
        rst = 1'b0;
        #1;
        check("abort mem_wr", mem_wr, 0);
        check("abort ls_busy", ls_busy, 0);
        check("abort mem_a", mem_a, 0);
        tick();
        rst = 1'b1;
        n_done = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (ls_done) n_done++;
        end
        check("abort no ls_done", n_done, 0);
        fetch_expect("after abort 0x0300", 32'h0300, 8, 32'h0010_0093, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_nway.md
# icache_nway

Parametrised N-way set-associative instruction cache with an integrated byte-serial memory sequencer shared with the load/store unit. Sits between the fetch stage, the LSU and the 8-bit RAM/IO bus. Generalises the 2-way design:
- configurable ways, sets and address width
- round-robin replacement
- store-snoop invalidation
- honours `rdy`
- single clock edge only

## Interface
Parameters:
- `WAYS`, 2 — associativity; power of two, 1..8.
- `SET_WIDTH`, 9 — log2(sets).
- `ADDR_WIDTH`, 17 — cached address bits; tag = `ADDR_WIDTH-SET_WIDTH-2` bits.

Ports:
- `clk` in 1 — clock, rising edge only.
- `rst` in 1 — reset, asynchronous, active-low.
- `rdy` in 1 — global ready; low freezes all state.
- `if_req` in 1 — fetch lookup request.
- `if_addr` in 32 — fetch address, word aligned.
- `if_hit` out 1 — `if_inst` valid.
- `if_inst` out 32 — instruction word.
- `ls_req` in 1 — load/store request.
- `ls_we` in 1 — 1 = store.
- `ls_addr` in 32 — byte address, aligned to `ls_size`.
- `ls_size` in 3 — byte count: 1, 2 or 4.
- `ls_wdata` in 32 — store data, little-endian.
- `ls_busy` out 1 — request in progress.
- `ls_done` out 1 — one-cycle completion pulse.
- `ls_rdata` out 32 — load data, zero-extended.
- `mem_din` in 8 — RAM read byte, one cycle after address.
- `mem_dout` out 8 — RAM write byte.
- `mem_a` out 32 — RAM address.
- `mem_wr` out 1 — 1 = write.

## Operation
- Reset (asserted): all valid bits cleared, all victim pointers set to 0, FSM to IDLE. All outputs are 0. Tag/data arrays are not reset.
- Lookup:
  - `if_req` in cycle t → `if_hit`/`if_inst` registered in t+1.
  - Hit: any way valid with matching tag.
  - Miss: `if_hit`=0, and the word address is latched into a pending-refill register if that register is empty.
  - Lookups continue during any FSM state.
- FSM states: IDLE, LOAD, STORE, REFILL.
  - Leaving IDLE, priority is accepted LSU request, then pending refill.
  - LOAD/STORE/REFILL return to IDLE after the last byte.
- LSU handshake:
  - A request is accepted when `ls_req` & !`ls_busy` & IDLE & `rdy`.
  - Operands are latched on acceptance.
  - `ls_busy`=1 from the next cycle until the cycle `ls_done` pulses.
  - `ls_req` is ignored while busy.
- LOAD: reads bytes `addr+i`, i=0..n-1. `ls_rdata` = {0, b(n-1)..b0}.
- STORE:
  - Writes byte i of `ls_wdata` to `addr+i`, with `mem_wr`=1 for each byte.
  - On completion, every way whose tag/set matches the word containing `addr` is invalidated.
  - A pending refill for the same word is kept.
- REFILL:
  - Reads 4 bytes of the pending word, little-endian.
  - Writes the line into the first invalid way, else into the way at the set's victim pointer; the pointer then increments mod `WAYS`.
  - Clears the pending register.
  - The refill completes even if `if_addr` has changed.
- Idle bus: `mem_a`=0, `mem_wr`=0, `mem_dout`=0.
- `rdy`=0:
  - All registers hold; `mem_wr` forced 0 in that cycle.
  - Bytes in flight are re-captured: the byte counter does not advance and the address is re-issued.
- Reset mid-operation: the transfer is abandoned, `mem_wr` drops immediately, and no `ls_done` is issued.

## Timing
- Hit latency: 1 cycle.
- LOAD of n bytes accepted at t:
  - `mem_a`=`addr+i` at t+1+i.
  - Byte i captured at the end of t+2+i.
  - `ls_done` at t+n+2.
- STORE of n bytes accepted at t: `mem_wr`=1 at t+1..t+n; `ls_done` at t+n+1.
- REFILL starting in IDLE at t: `mem_a` at t+1..t+4, line written at the end of t+5, so a lookup at t+6 hits.
- Miss-to-hit, with an idle FSM and `if_req` held: `if_hit`=1 in cycle miss+7.
- Back-to-back operations: the next FSM operation may start in the cycle after the one returning to IDLE.

## Structure
- `icache_pkg`:
  - FSM state encoding.
  - Size codes.
  - `BYTE_W`=8 and `WORD_W`=32.
  - Little-endian byte-select helper function.
- Sub-module `icache_way`, one instance per way (generate):
  - Valid bits with asynchronous clear.
  - Tag and data arrays.
  - Read port, write port and invalidate port.
  - Match output.
- Top level contains the lookup mux, victim pointers and FSM.

## Test plan
- Cold fetch of 0x1000, RAM bytes 13 05 00 00 → `if_hit`=0, then `if_hit`=1 at +7 with `if_inst`=0x00000513. A repeat fetch hits in 1 cycle.
- `WAYS`=2: fetch three addresses mapping to one set (0x0000, 0x0800, 0x1000) → the third evicts way 0. A refetch of 0x0000 misses; a refetch of 0x0800 hits.
- Load of size 2 at 0x0104, RAM EF BE → `ls_rdata`=0x0000BEEF. `ls_done` at acceptance+4 while a concurrent pending refill waits.
- Store of size 4, 0xDEADBEEF, to a cached word 0x1000:
  - `mem_wr` pulses for 4 cycles with bytes EF BE AD DE.
  - The next fetch of 0x1000 misses and returns 0xDEADBEEF.
- `rdy` low for 3 cycles mid-refill → identical byte sequence and the correct line; latency is extended by 3.
- `rst` asserted mid-store → `mem_wr`=0 immediately, all lines invalid, and no `ls_done`.
